// File: rtl/input_memory_bank_pkg.sv
// input_memory_bank_pkg: shared FSM encoding and default geometry for the input memory bank
package input_memory_bank_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 6;
  typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;
endpackage

// File: rtl/imem_ram_core.sv
// imem_ram_core: unreset storage with one synchronous write port and one synchronous read-first read port
module imem_ram_core #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
)(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  // write port
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // read port: samples old contents on a same-address write, holds when idle
  always_ff @(posedge clk)
    if (re) q <= mem[raddr];
endmodule

// File: rtl/input_memory_bank.sv
// input_memory_bank: RAM bank zero-filled by a sweep after reset or clr; INPUT_MEMORY_BANK_BYPASS_EN enables write-first forwarding
module input_memory_bank
  import input_memory_bank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              access_err
);
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, ram_waddr;
  logic [DATA_W-1:0] ram_wdata, ram_q;
  logic              acc_ok, wr_ok, rd_ok, ram_we, has_rd;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_CLEAR;
    else state <= state_nxt;
  // next state: clr always (re)starts a sweep; the sweep ends after writing the last word
  always_comb
    state_nxt = clr ? ST_CLEAR : (state == ST_CLEAR && !(&clr_cnt)) ? ST_CLEAR : ST_IDLE;
  // outputs and RAM port steering: the sweep owns the write port, clr suppresses user accesses
  always_comb begin
    busy      = state == ST_CLEAR;
    acc_ok    = !busy && !clr;
    wr_ok     = acc_ok && wr_en;
    rd_ok     = acc_ok && rd_en;
    ram_we    = busy || wr_ok;
    ram_waddr = busy ? clr_cnt : wr_addr;
    ram_wdata = busy ? '0 : wr_data;
  end
  // sweep counter, read qualifier and sticky access error
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      clr_cnt    <= '0;
      rd_valid   <= 1'b0;
      has_rd     <= 1'b0;
      access_err <= 1'b0;
    end else begin
      clr_cnt    <= (busy && !clr) ? clr_cnt + 1'b1 : '0;
      rd_valid   <= rd_ok;
      has_rd     <= has_rd || rd_ok;
      access_err <= (!busy && clr) ? 1'b0 : access_err || (busy && (wr_en || rd_en));
    end
  imem_ram_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (rd_ok),
    .raddr (rd_addr),
    .q     (ram_q)
  );
`ifdef INPUT_MEMORY_BANK_BYPASS_EN
  logic              fwd_sel;
  logic [DATA_W-1:0] fwd_data;
  // capture write data when a read hits the address being written this cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fwd_sel  <= 1'b0;
      fwd_data <= '0;
    end else if (rd_ok) begin
      fwd_sel  <= wr_ok && wr_addr == rd_addr;
      fwd_data <= wr_data;
    end
  assign rd_data = !has_rd ? '0 : fwd_sel ? fwd_data : ram_q;
`else
  assign rd_data = has_rd ? ram_q : '0;
`endif
endmodule

// File: tb/tb_input_memory_bank.sv
// tb_input_memory_bank: directed self-checking bench for input_memory_bank
module tb_input_memory_bank;
  logic        clk = 1'b0, rst_n = 1'b0, clr = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [5:0]  wr_addr = '0, rd_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        rd_valid, busy, access_err;
  int          tests = 0, fails = 0, n;

  input_memory_bank dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .access_err(access_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
    rd_en = 1'b1; rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    chk({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
    chk({tag, "_data"}, rd_data, exp);
    @(negedge clk);
    chk({tag, "_valid_drop"}, {31'd0, rd_valid}, 32'd0);
    chk({tag, "_hold"}, rd_data, exp);
  endtask

  task automatic busy_len(input string tag);
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n, 32'd64);
  endtask

  initial begin
    #2;
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_access_err", {31'd0, access_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    busy_len("sweep_len_after_reset");
    rd_chk("rd0_after_sweep", 6'd0, 32'd0);
    rd_chk("rd63_after_sweep", 6'd63, 32'd0);
    wr(6'd5, 32'hDEADBEEF);
    rd_chk("rd5", 6'd5, 32'hDEADBEEF);
    wr(6'd9, 32'hA5A5A5A5);
    wr_en = 1'b1; wr_addr = 6'd9; wr_data = 32'h12345678;
`ifdef INPUT_MEMORY_BANK_BYPASS_EN
    rd_chk("same_addr_rw", 6'd9, 32'h12345678);
`else
    rd_chk("same_addr_rw", 6'd9, 32'hA5A5A5A5);
`endif
    rd_chk("rd9_after_rw", 6'd9, 32'h12345678);
    wr_en = 1'b1; wr_addr = 6'd10; wr_data = 32'h0BADF00D;
    rd_chk("diff_addr_rw", 6'd5, 32'hDEADBEEF);
    rd_chk("rd10", 6'd10, 32'h0BADF00D);
    chk("no_err_idle", {31'd0, access_err}, 32'd0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("busy_after_clr", {31'd0, busy}, 32'd1);
    repeat (20) @(negedge clk);
    rd_en = 1'b1; rd_addr = 6'd5; wr_en = 1'b1; wr_addr = 6'd5; wr_data = 32'h55555555;
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
    chk("sweep_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("sweep_access_err", {31'd0, access_err}, 32'd1);
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("sweep_ends", {31'd0, busy}, 32'd0);
    chk("err_sticky_idle", {31'd0, access_err}, 32'd1);
    rd_chk("rd5_ignored_wr", 6'd5, 32'd0);
    chk("err_sticky_after_rd", {31'd0, access_err}, 32'd1);
    wr(6'd63, 32'hCAFEF00D);
    rd_chk("rd63_before_clr", 6'd63, 32'hCAFEF00D);
    clr = 1'b1; wr_en = 1'b1; wr_addr = 6'd62; wr_data = 32'h77777777;
    @(negedge clk);
    clr = 1'b0; wr_en = 1'b0;
    chk("clr_clears_err", {31'd0, access_err}, 32'd0);
    repeat (30) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    busy_len("sweep_len_after_midclr");
    chk("no_err_clr_wr", {31'd0, access_err}, 32'd0);
    rd_chk("rd63_after_clr", 6'd63, 32'd0);
    rd_chk("rd62_clr_wins", 6'd62, 32'd0);
    wr(6'd3, 32'h33333333);
    rd_en = 1'b1; rd_addr = 6'd3;
    @(posedge clk);
    #2;
    chk("rd3_valid", {31'd0, rd_valid}, 32'd1);
    chk("rd3_data", rd_data, 32'h33333333);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rd_data", rd_data, 32'd0);
    chk("rst_mid_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd1);
    rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    busy_len("sweep_len_after_rst");
    rd_chk("rd3_after_rst", 6'd3, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/input_memory_bank.md
INPUT_MEMORY_BANK -- requirements
Module: input_memory_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 6, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port clr  input  1  one-cycle request to restart the zero-fill sweep.
REQ-006 SHALL have port wr_en  input  1  write strobe.
REQ-007 SHALL have port wr_addr  input  ADDR_W  write address.
REQ-008 SHALL have port wr_data  input  DATA_W  write data.
REQ-009 SHALL have port rd_en  input  1  read request.
REQ-010 SHALL have port rd_addr  input  ADDR_W  read address.
REQ-011 SHALL have port rd_data  output  DATA_W  registered read data.
REQ-012 SHALL have port rd_valid  output  1  one-cycle pulse qualifying rd_data.
REQ-013 SHALL have port busy  output  1  high while zero-fill sweep runs.
REQ-014 SHALL have port access_err  output  1  sticky flag: access attempted while busy.

Function
REQ-015 SHALL implement a two-state FSM: ST_CLEAR, ST_IDLE.
REQ-016 In ST_CLEAR: write 0 to word clr_cnt, increment clr_cnt each cycle; busy = 1.
REQ-017 ST_CLEAR -> ST_IDLE on the cycle clr_cnt == DEPTH-1 is written; clr_cnt wraps to 0; sweep lasts exactly DEPTH cycles.
REQ-018 ST_IDLE -> ST_CLEAR when clr = 1; clr_cnt restarts at 0.
REQ-019 clr = 1 in ST_CLEAR restarts clr_cnt at 0; full DEPTH-cycle sweep follows.
REQ-020 In ST_IDLE, wr_en = 1 writes wr_data to wr_addr at the clock edge.
REQ-021 In ST_IDLE, rd_en = 1 loads mem[rd_addr] into rd_data next edge; rd_valid = 1 that cycle; latency 1.
REQ-022 rd_en = 0: rd_valid = 0, rd_data holds last value; output never tri-stated.
REQ-023 In ST_CLEAR, wr_en and rd_en are ignored (no write, rd_valid = 0); either set access_err.
REQ-024 access_err clears only on reset or on clr in ST_IDLE.
REQ-025 Same-address read and write in one ST_IDLE cycle: rd_data returns old contents (read-first) unless REQ-030 applies.
REQ-026 clr and wr_en/rd_en in same ST_IDLE cycle: clr wins, access ignored, access_err not set.

Reset
REQ-027 rst_n = 0 SHALL immediately force state ST_CLEAR, clr_cnt 0, rd_data 0, rd_valid 0, access_err 0, busy 1.
REQ-028 Memory array SHALL have no reset; contents zeroed only by the sweep after rst_n rises.
REQ-029 rst_n asserted mid-sweep or mid-read SHALL abort it; full sweep restarts on release.

Configuration
REQ-030 Macro INPUT_MEMORY_BANK_BYPASS_EN defined: same-address read/write in ST_IDLE returns wr_data (write-first forwarding); undefined: read-first per REQ-025.

Structure
REQ-031 Package input_memory_bank_pkg SHALL hold FSM state encoding (ST_CLEAR, ST_IDLE) and default DATA_W/ADDR_W constants.
REQ-032 Storage SHALL be sub-module imem_ram_core: one sync write port, one sync read port, no reset, parameters DATA_W/ADDR_W.
REQ-033 FSM, sweep counter, forwarding mux and flags SHALL reside in input_memory_bank.

Verification
REQ-034 Release rst_n at t0 -> busy = 1 for exactly 64 cycles, then 0; read of any address returns 0.
REQ-035 IDLE: write 0xDEADBEEF to addr 5, next cycle rd_en addr 5 -> rd_data = 0xDEADBEEF, rd_valid high exactly one cycle.
REQ-036 Same-cycle write 0x12345678 and read, addr 9 (old 0xA5A5A5A5) -> 0xA5A5A5A5 without macro, 0x12345678 with INPUT_MEMORY_BANK_BYPASS_EN.
REQ-037 rd_en during sweep -> rd_valid stays 0, access_err = 1 and stays set until clr in ST_IDLE.
REQ-038 clr at sweep cycle 30 -> busy extends to 64 cycles after clr; addr 63 written before clr reads 0.
REQ-039 rst_n pulsed low during read of addr 3 -> rd_data = 0, rd_valid = 0 at once; new 64-cycle sweep follows.
